// File: rtl/vga_pkg.sv
// Shared timing constants and bundle types for the VGA path.
// Default 640x480@60 raster, 11-bit counters, 24-bit colour.
package vga_pkg;

  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_VIS  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  typedef logic [10:0] raster_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic de;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register of sync bundles, advancing only on pixel ticks.
// Depth 0 is a straight pass-through.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  sync_bundle_t d_i,
  output sync_bundle_t q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_shift
    sync_bundle_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++)
          stage_q[i] <= SYNC_IDLE;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++)
          stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// Raster counters, VRAM address issue and sync/colour alignment
// for the DAC-side VGA pins, all in the single Clk domain.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS  = VGA_H_VIS,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_VIS  = VGA_V_VIS,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [10:0] PixelX,
  output logic [10:0] PixelY,
  output logic        PixelReq,
  input  logic [23:0] PixelData,
  output logic        FrameStart,
  output logic [23:0] VGA_Pixel,
  output logic        VGA_Clk,
  output logic        VGA_sync,
  output logic        VGA_blank,
  output logic        Hsync,
  output logic        Vsync
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam raster_t H_LAST = raster_t'(H_TOT - 1);
  localparam raster_t V_LAST = raster_t'(V_TOT - 1);
  localparam raster_t H_VR   = raster_t'(H_VIS);
  localparam raster_t V_VR   = raster_t'(V_VIS);
  localparam raster_t HS_BEG = raster_t'(H_VIS + H_FP);
  localparam raster_t HS_END = raster_t'(H_VIS + H_FP + H_SYNC);
  localparam raster_t VS_BEG = raster_t'(V_VIS + V_FP);
  localparam raster_t VS_END = raster_t'(V_VIS + V_FP + V_SYNC);

  logic         pix_ce_q;
  logic         vclk_q;
  logic         fs_q;
  logic         hs_q;
  logic         vs_q;
  logic         blank_q;
  rgb_t         pix_q;
  raster_t      h_q, h_d;
  raster_t      v_q, v_d;
  sync_bundle_t raw;
  sync_bundle_t dly;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_ce_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + raster_t'(1);
      end else begin
        h_d = h_q + raster_t'(1);
      end
    end
  end

  always_comb begin
    raw      = SYNC_IDLE;
    raw.de   = (h_q < H_VR) && (v_q < V_VR);
    raw.hs_n = !((h_q >= HS_BEG) && (h_q < HS_END));
    raw.vs_n = !((v_q >= VS_BEG) && (v_q < VS_END));
  end

  vga_sync_delay #(
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk_i (Clk),
    .rst_i (Rst),
    .en_i  (pix_ce_q),
    .d_i   (raw),
    .q_o   (dly)
  );

  // VGA_Clk mirrors pix_ce: it rises on the Clk edge between ticks.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pix_ce_q <= 1'b0;
      vclk_q   <= 1'b0;
      fs_q     <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      pix_q    <= '0;
    end else begin
      pix_ce_q <= ~pix_ce_q;
      vclk_q   <= ~pix_ce_q;
      fs_q     <= pix_ce_q && (h_q == '0) && (v_q == '0);
      h_q      <= h_d;
      v_q      <= v_d;
      if (pix_ce_q) begin
        hs_q    <= dly.hs_n;
        vs_q    <= dly.vs_n;
        blank_q <= dly.de;
        pix_q   <= dly.de ? rgb_t'(PixelData) : '0;
      end
    end
  end

  assign PixelX     = h_q;
  assign PixelY     = v_q;
  assign PixelReq   = raw.de;
  assign FrameStart = fs_q;
  assign VGA_Pixel  = pix_q;
  assign VGA_Clk    = vclk_q;
  assign VGA_sync   = 1'b0;
  assign VGA_blank  = blank_q;
  assign Hsync      = hs_q;
  assign Vsync      = vs_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench: several DUTs (full 640x480 and a shrunken raster at several
// read latencies) against a tick-count reference model.
module tb_vga_timing_pipe;

  localparam int NI  = 6;
  localparam int CYC = 8000;

  localparam int P_HV [NI] = '{640, 16, 16, 16, 16, 16};
  localparam int P_HF [NI] = '{16, 4, 4, 4, 4, 4};
  localparam int P_HS [NI] = '{96, 6, 6, 6, 6, 6};
  localparam int P_HB [NI] = '{48, 4, 4, 4, 4, 4};
  localparam int P_VV [NI] = '{480, 6, 6, 6, 6, 6};
  localparam int P_VF [NI] = '{10, 2, 2, 2, 2, 2};
  localparam int P_VS [NI] = '{2, 2, 2, 2, 2, 2};
  localparam int P_VB [NI] = '{33, 2, 2, 2, 2, 2};
  localparam int P_RL [NI] = '{2, 2, 0, 1, 5, 7};

  logic clk = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int HV = P_HV[g];
    localparam int HF = P_HF[g];
    localparam int HS = P_HS[g];
    localparam int HB = P_HB[g];
    localparam int VV = P_VV[g];
    localparam int VF = P_VF[g];
    localparam int VS = P_VS[g];
    localparam int VB = P_VB[g];
    localparam int RL = P_RL[g];
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int TOT = HT * VT;
    localparam bit RST_EN = (g != 0);

    logic        rst;
    logic [23:0] pd;
    logic [10:0] px, py;
    logic        preq, fs, vclk, vsy;
    logic        vblank, hs, vs;
    logic [23:0] vpix;

    vga_timing_pipe #(
      .H_VIS (HV), .H_FP (HF),
      .H_SYNC(HS), .H_BP (HB),
      .V_VIS (VV), .V_FP (VF),
      .V_SYNC(VS), .V_BP (VB),
      .RD_LAT(RL)
    ) dut (
      .Clk       (clk),
      .Rst       (rst),
      .PixelX    (px),
      .PixelY    (py),
      .PixelReq  (preq),
      .PixelData (pd),
      .FrameStart(fs),
      .VGA_Pixel (vpix),
      .VGA_Clk   (vclk),
      .VGA_sync  (vsy),
      .VGA_blank (vblank),
      .Hsync     (hs),
      .Vsync     (vs)
    );

    initial begin
      string       pfx;
      int          e, n, p, hn, vn, m, hm, vm;
      int          mode, tgt, rcnt;
      bit          xde, xhs, xvs, xfs;
      logic [23:0] xpix, tick_pd;
      logic [23:0] vr [8];
      logic        p_hs, p_vs, p_bl, p_fs;
      int          hf_c, vf_c, bl_c, fs_c;
      bit          hf_ok, vf_ok, bl_ok, fs_ok;

      pfx = $sformatf("u%0d.", g);
      rst = 1'b1;
      pd = 24'($urandom);
      e = 0; mode = 0; tgt = -1; rcnt = 0;
      tick_pd = '0;
      for (int i = 0; i < 8; i++)
        vr[i] = 24'($urandom);
      p_hs = 1'b1; p_vs = 1'b1;
      p_bl = 1'b0; p_fs = 1'b0;
      hf_c = 0; vf_c = 0; bl_c = 0; fs_c = 0;
      hf_ok = 0; vf_ok = 0; bl_ok = 0; fs_ok = 0;

      for (int c = 0; c < CYC; c++) begin
        @(negedge clk);
        if (rst) e = 0;
        else e++;
        if (!rst && (e % 2 == 0))
          tick_pd = pd;

        n  = e / 2;
        p  = n % TOT;
        hn = p % HT;
        vn = p / HT;
        xfs = (e % 2 == 0) && (n >= 1)
              && ((n - 1) % TOT == 0);
        if (n >= RL + 1) begin
          m  = (n - RL - 1) % TOT;
          hm = m % HT;
          vm = m / HT;
          xde = (hm < HV) && (vm < VV);
          xhs = !((hm >= HV + HF) && (hm < HV + HF + HS));
          xvs = !((vm >= VV + VF) && (vm < VV + VF + VS));
        end else begin
          hm = 0; vm = 0;
          xde = 0; xhs = 1; xvs = 1;
        end
        if (!xde) xpix = '0;
        else if (mode == 0)
          xpix = {8'(hm), 8'(vm), 8'hA5};
        else xpix = tick_pd;

        check({pfx, "px"}, 32'(px), hn);
        check({pfx, "py"}, 32'(py), vn);
        check({pfx, "preq"}, 32'(preq),
              32'((hn < HV) && (vn < VV)));
        check({pfx, "vclk"}, 32'(vclk), e % 2);
        check({pfx, "fs"}, 32'(fs), 32'(xfs));
        check({pfx, "vga_sync"}, 32'(vsy), 0);
        check({pfx, "hsync"}, 32'(hs), 32'(xhs));
        check({pfx, "vsync"}, 32'(vs), 32'(xvs));
        check({pfx, "blank"}, 32'(vblank), 32'(xde));
        check({pfx, "pixel"}, 32'(vpix), 32'(xpix));

        if (xde && mode == 0 && vm == 0) begin
          if (hm == 0)
            check({pfx, "first_pix"}, 32'(vpix),
                  32'h0000A5);
          if (hm == HV - 1)
            check({pfx, "last_pix"}, 32'(vpix),
                  {8'h0, 8'(HV - 1), 16'h00A5});
        end

        if (e == 0) begin
          hf_ok = 0; vf_ok = 0;
          bl_ok = 0; fs_ok = 0;
        end else begin
          if (p_hs && !hs) begin
            if (hf_ok)
              check({pfx, "hs_period"}, c - hf_c, 2 * HT);
            hf_c = c; hf_ok = 1;
          end
          if (!p_hs && hs && hf_ok)
            check({pfx, "hs_width"}, c - hf_c, 2 * HS);
          if (p_vs && !vs) begin
            vf_c = c; vf_ok = 1;
          end
          if (!p_vs && vs && vf_ok)
            check({pfx, "vs_width"}, c - vf_c,
                  2 * VS * HT);
          if (!p_bl && vblank) begin
            bl_c = c; bl_ok = 1;
          end
          if (p_bl && !vblank && bl_ok)
            check({pfx, "blank_width"}, c - bl_c, 2 * HV);
          if (!p_fs && fs) begin
            if (fs_ok)
              check({pfx, "fs_period"}, c - fs_c, 2 * TOT);
            fs_c = c; fs_ok = 1;
          end
        end
        p_hs = hs; p_vs = vs;
        p_bl = vblank; p_fs = fs;

        if (rst) begin
          rst = 1'b0;
          if (RST_EN) begin
            mode = $urandom_range(0, 2);
            // even resets land inside both sync pulses
            if (rcnt % 2 == 0)
              tgt = 2 * (TOT + (VV + VF + VS - 1) * HT
                         + HV + HF + HS / 2)
                    + $urandom_range(0, 1);
            else
              tgt = $urandom_range(20, 4 * TOT);
            rcnt++;
          end
        end else if (e == tgt) begin
          rst = 1'b1;
        end

        if (!rst && ((e + 1) % 2 == 0)) begin
          if (mode == 0) begin
            for (int i = 7; i > 0; i--)
              vr[i] = vr[i-1];
            vr[0] = {px[7:0], py[7:0], 8'hA5};
            pd = vr[RL];
          end else if (mode == 1) begin
            pd = 24'hFFFFFF;
          end else begin
            pd = 24'($urandom);
          end
        end else begin
          pd = (mode == 1) ? 24'hFFFFFF
                           : 24'($urandom);
        end
      end
      n_done++;
    end
  end

  initial begin
    repeat (CYC + 4) @(posedge clk);
    check("all_done", n_done, NI);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
